// File: rtl/lab2_nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// lab2_nibble_serial_sub
//   Nibble-serial subtractor sequencer: computes diff = a - b - bin over
//   NIBBLES clocks by driving an external combinational 4-bit borrow-lookahead
//   slice one nibble per cycle (least significant nibble first) and collecting
//   its Diff/Bout. Start/busy/done handshake toward the host.
//
//   Optional feature macro: SUB_OVF_EN -- adds the registered signed-overflow
//   output ovf, updated on the same edge as bout.
//
// Parameters
//   NIBBLES     operand width in nibbles (1..16), W = 4*NIBBLES
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  operation request, sampled only in IDLE
//   a, b        in   W  minuend / subtrahend, captured on accepted start
//   bin         in   1  borrow-in, captured on accepted start
//   slice_x     out  4  current nibble of captured a
//   slice_y     out  4  current nibble of captured b
//   slice_bin   out  1  running borrow into the slice
//   slice_diff  in   4  slice difference (combinational, same cycle)
//   slice_bout  in   1  slice borrow-out (combinational, same cycle)
//   busy        out  1  high while nibbles are being processed
//   done        out  1  one-cycle pulse when diff/bout are valid
//   diff        out  W  registered result
//   bout        out  1  final borrow-out (a < b + bin, unsigned)
//   ovf         out  1  signed overflow (SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module lab2_nibble_serial_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   bin,
  output logic [3:0]             slice_x,
  output logic [3:0]             slice_y,
  output logic                   slice_bin,
  input  logic [3:0]             slice_diff,
  input  logic                   slice_bout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   bout
`ifdef SUB_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_diff;
  logic             r_bout;
  logic [3:0]       w_x;
  logic [3:0]       w_y;

  // Nibble select by comparison against every index; keeps the select free
  // of index-width corner cases across the whole NIBBLES range.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_x = r_a[4*i +: 4];
        w_y = r_b[4*i +: 4];
      end
    end
  end

`ifdef SUB_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // The slice's MSB output on the final nibble is the result sign bit.
  assign w_ovf_next = (r_a[W-1] != r_b[W-1]) && (slice_diff[3] != r_a[W-1]);
  assign ovf        = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && r_cnt == LAST_CNT) begin
      r_ovf <= w_ovf_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CNT_W'(i)) r_diff[4*i +: 4] <= slice_diff;
          end
          r_borrow <= slice_bout;
          if (r_cnt == LAST_CNT) begin
            r_bout  <= slice_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // start is deliberately ignored here
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign slice_x   = w_x;
  assign slice_y   = w_y;
  assign slice_bin = r_borrow;
  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule
